// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM command arbiter: FSM state encoding,
// SDRAM command codes ({cs_n, ras_n, cas_n, we_n}) and the idle bank value.
// No ports; imported by sdram_arbiter and sdram_cmd_mux.
// ---------------------------------------------------------------------------
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  // SDRAM commands encoded as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_MRS       = 4'b0000;

  // Bank driven while idle or refreshing; idle address is all-ones at any width
  localparam logic [1:0] DEF_BANK = 2'b11;

endpackage

// File: rtl/sdram_cmd_mux.sv
// ---------------------------------------------------------------------------
// sdram_cmd_mux
// Pure combinational selector: routes the command/bank/address of whichever
// requester owns the bus (selected by the arbiter state) to the SDRAM pins,
// and raises the DQ output enable only for an owned write with wr_oe set.
// Ports:
//   i_state                         current arbiter state (select)
//   i_init_* / i_aref_* / i_wr_* / i_rd_*   requester command, bank, address
//   i_wr_oe                         write requester wants to drive DQ
//   o_cmd                           {cs_n, ras_n, cas_n, we_n}
//   o_ba, o_addr                    bank and address to the SDRAM
//   o_dq_oe                         DQ output enable
// ---------------------------------------------------------------------------
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  state_e            i_state,
  input  logic [3:0]        i_init_cmd,
  input  logic [1:0]        i_init_ba,
  input  logic [ADDR_W-1:0] i_init_addr,
  input  logic [3:0]        i_aref_cmd,
  input  logic [ADDR_W-1:0] i_aref_addr,
  input  logic [3:0]        i_wr_cmd,
  input  logic [1:0]        i_wr_ba,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_wr_oe,
  input  logic [3:0]        i_rd_cmd,
  input  logic [1:0]        i_rd_ba,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [3:0]        o_cmd,
  output logic [1:0]        o_ba,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_dq_oe
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned; otherwise synthesis infers a latch.
    o_cmd   = CMD_NOP;
    o_ba    = DEF_BANK;
    o_addr  = '1;
    o_dq_oe = 1'b0;
    unique case (i_state)
      ST_INIT: begin
        o_cmd  = i_init_cmd;
        o_ba   = i_init_ba;
        o_addr = i_init_addr;
      end
      ST_AREF: begin
        o_cmd  = i_aref_cmd;
        o_addr = i_aref_addr;
      end
      ST_WRITE: begin
        o_cmd   = i_wr_cmd;
        o_ba    = i_wr_ba;
        o_addr  = i_wr_addr;
        o_dq_oe = i_wr_oe;
      end
      ST_READ: begin
        o_cmd  = i_rd_cmd;
        o_ba   = i_rd_ba;
        o_addr = i_rd_addr;
      end
      default: ; // ST_ARBIT: idle NOP from the defaults
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
// Owns the SDRAM command bus on behalf of four requesters: init sequencer,
// auto-refresh, write and read. After init completes, an idle ARBIT state
// picks one requester per transaction (refresh > write > read) and holds
// that grant, without preemption, until the requester pulses its *_end.
// Optional build macro SDRAM_ARB_RR_EN: when write and read are both pending
// (and no refresh), alternate between them using a last-served flag.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   init_end/init_cmd/init_ba/init_addr  init sequencer
//   aref_req/aref_end/aref_cmd/aref_addr auto-refresh requester
//   wr_req/wr_end/wr_cmd/wr_ba/wr_addr/wr_oe/wr_data  write requester
//   rd_req/rd_end/rd_cmd/rd_ba/rd_addr   read requester
//   aref_en/wr_en/rd_en                grants
//   sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
//   sdram_bank, sdram_addr, sdram_dq   SDRAM pins
// ---------------------------------------------------------------------------
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_oe,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  state_e            r_state;
  state_e            w_next_state;
  logic              w_pick_write;
  logic [3:0]        w_cmd;
  logic              w_dq_oe;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_next_state;
  end

`ifdef SDRAM_ARB_RR_EN
  // 1 = write was served last. Resets to "read" so write wins first contest.
  logic r_last_wr;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_last_wr <= 1'b0;
    else if (r_state == ST_ARBIT && w_next_state == ST_WRITE)
      r_last_wr <= 1'b1;
    else if (r_state == ST_ARBIT && w_next_state == ST_READ)
      r_last_wr <= 1'b0;
  end

  // Write wins unless read is also waiting and write went last
  assign w_pick_write = wr_req && !(rd_req && r_last_wr);
`else
  assign w_pick_write = wr_req;
`endif

  // Next-state logic: requests are sampled only in ARBIT; *_end is honoured
  // only from the requester that currently owns the bus.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_INIT:  if (init_end) w_next_state = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)          w_next_state = ST_AREF;
        else if (w_pick_write) w_next_state = ST_WRITE;
        else if (rd_req)       w_next_state = ST_READ;
      end
      ST_AREF:  if (aref_end) w_next_state = ST_ARBIT;
      ST_WRITE: if (wr_end)   w_next_state = ST_ARBIT;
      ST_READ:  if (rd_end)   w_next_state = ST_ARBIT;
      default:  w_next_state = ST_INIT;
    endcase
  end

  // Output logic: grants follow the state, so at most one is ever high
  always_comb begin
    aref_en = (r_state == ST_AREF);
    wr_en   = (r_state == ST_WRITE);
    rd_en   = (r_state == ST_READ);
  end

  sdram_cmd_mux #(
    .ADDR_W (ADDR_W)
  ) u_cmd_mux (
    .i_state     (r_state),
    .i_init_cmd  (init_cmd),
    .i_init_ba   (init_ba),
    .i_init_addr (init_addr),
    .i_aref_cmd  (aref_cmd),
    .i_aref_addr (aref_addr),
    .i_wr_cmd    (wr_cmd),
    .i_wr_ba     (wr_ba),
    .i_wr_addr   (wr_addr),
    .i_wr_oe     (wr_oe),
    .i_rd_cmd    (rd_cmd),
    .i_rd_ba     (rd_ba),
    .i_rd_addr   (rd_addr),
    .o_cmd       (w_cmd),
    .o_ba        (sdram_bank),
    .o_addr      (sdram_addr),
    .o_dq_oe     (w_dq_oe)
  );

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
  assign sdram_cke = 1'b1;
  assign sdram_dq  = w_dq_oe ? wr_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed and randomized stimulus for sdram_arbiter, compared every cycle
// against a transaction-level model of bus ownership. The DQ bus carries a
// pull-up so a released bus reads as all-ones.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

`ifdef SDRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // Bus owner in the model
  localparam int OWN_INIT = 0;
  localparam int OWN_IDLE = 1;
  localparam int OWN_AREF = 2;
  localparam int OWN_WR   = 3;
  localparam int OWN_RD   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [1:0]        init_ba;
  logic [ADDR_W-1:0] init_addr;
  logic              aref_req, aref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              wr_req, wr_end, wr_oe;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req, rd_end;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_ba;
  logic [ADDR_W-1:0] rd_addr;
  logic              aref_en, wr_en, rd_en;
  logic              sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]        sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  tri1  [DATA_W-1:0] sdram_dq;

  int n_pass  = 0;
  int n_total = 0;

  int owner;      // model: who owns the bus
  bit last_wr;    // model: write served most recently

  always #5 clk = ~clk;

  sdram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_oe(wr_oe), .wr_data(wr_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Compare every output against what the current owner implies
  task automatic check_outputs();
    logic [3:0]        e_cmd;
    logic [1:0]        e_ba;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_dq;
    e_cmd  = 4'b0111;
    e_ba   = 2'b11;
    e_addr = {ADDR_W{1'b1}};
    e_dq   = {DATA_W{1'b1}};
    case (owner)
      OWN_INIT: begin e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr; end
      OWN_AREF: begin e_cmd = aref_cmd; e_addr = aref_addr; end
      OWN_WR: begin
        e_cmd = wr_cmd; e_ba = wr_ba; e_addr = wr_addr;
        if (wr_oe) e_dq = wr_data;
      end
      OWN_RD: begin e_cmd = rd_cmd; e_ba = rd_ba; e_addr = rd_addr; end
      default: ;
    endcase
    check("cmd",     32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(e_cmd));
    check("bank",    32'(sdram_bank), 32'(e_ba));
    check("addr",    32'(sdram_addr), 32'(e_addr));
    check("aref_en", 32'(aref_en), 32'(owner == OWN_AREF));
    check("wr_en",   32'(wr_en),   32'(owner == OWN_WR));
    check("rd_en",   32'(rd_en),   32'(owner == OWN_RD));
    check("dq",      32'(sdram_dq), 32'(e_dq));
    check("cke",     32'(sdram_cke), 32'd1);
  endtask

  // Ownership rules applied at a clock edge
  task automatic model_edge();
    if (!rst_n) begin
      owner   = OWN_INIT;
      last_wr = 1'b0;
    end else begin
      case (owner)
        OWN_INIT: if (init_end) owner = OWN_IDLE;
        OWN_IDLE: begin
          if (aref_req) owner = OWN_AREF;
          else if (wr_req && !(RR_EN && rd_req && last_wr)) begin
            owner = OWN_WR; last_wr = 1'b1;
          end else if (rd_req) begin
            owner = OWN_RD; last_wr = 1'b0;
          end
        end
        OWN_AREF: if (aref_end) owner = OWN_IDLE;
        OWN_WR:   if (wr_end)   owner = OWN_IDLE;
        OWN_RD:   if (rd_end)   owner = OWN_IDLE;
        default:  owner = OWN_INIT;
      endcase
    end
  endtask

  // One cycle: check mid-cycle, advance model at the edge, return 1 after it
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic randomize_fields();
    init_cmd  = 4'($urandom);  init_ba = 2'($urandom);  init_addr = ADDR_W'($urandom);
    aref_cmd  = 4'($urandom);  aref_addr = ADDR_W'($urandom);
    wr_cmd    = 4'($urandom);  wr_ba = 2'($urandom);    wr_addr = ADDR_W'($urandom);
    wr_data   = DATA_W'($urandom_range(0, 16'hFFFE));
    rd_cmd    = 4'($urandom);  rd_ba = 2'($urandom);    rd_addr = ADDR_W'($urandom);
  endtask

  initial begin
    int waited;
    bit got_grant;
    rst_n = 1'b0; init_end = 1'b0;
    aref_req = 1'b0; aref_end = 1'b0;
    wr_req = 1'b0; wr_end = 1'b0; wr_oe = 1'b0;
    rd_req = 1'b0; rd_end = 1'b0;
    randomize_fields();
    repeat (2) @(posedge clk);
    owner = OWN_INIT; last_wr = 1'b0;
    #1;

    // Reset state: INIT, command pins follow init_*
    step();
    rst_n = 1'b1;

    // Init completes at cycle 10, ARBIT from cycle 11 with NOP and no grant
    for (int c = 1; c < 10; c++) begin
      randomize_fields();
      step();
    end
    init_end = 1'b1;
    step();
    check("arbit_nop", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h7);
    check("arbit_nogrant", 32'({aref_en, wr_en, rd_en}), 32'h0);
    step();

    // Request pulsed between samples is never seen
    wr_req = 1'b1; #2 wr_req = 1'b0;
    step();
    check("glitch_nogrant", 32'(wr_en), 32'h0);

    // Refresh beats write; write follows after aref_end
    aref_req = 1'b1; wr_req = 1'b1;
    step();
    check("aref_first", 32'({aref_en, wr_en}), 32'h2);
    aref_req = 1'b0;
    step();
    aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    check("back_to_arbit", 32'({aref_en, wr_en, rd_en}), 32'h0);
    step();
    check("write_after_aref", 32'(wr_en), 32'h1);

    // Write data on DQ, foreign end ignored, refresh does not preempt
    wr_req = 1'b0; wr_oe = 1'b1; wr_data = 16'h1234;
    step();
    check("dq_write", 32'(sdram_dq), 32'h1234);
    rd_end = 1'b1; aref_req = 1'b1;
    step();
    rd_end = 1'b0;
    check("rd_end_ignored", 32'(wr_en), 32'h1);

    // Reset mid-write aborts
    rst_n = 1'b0;
    step();
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_dq", 32'(sdram_dq), 32'hFFFF);
    rst_n = 1'b1; init_end = 1'b0; aref_req = 1'b0;
    step();
    step();
    check("rst_stays_init", 32'({aref_en, wr_en, rd_en}), 32'h0);
    init_end = 1'b1;
    step();

    // Write and read both held: alternate with RR, otherwise write every time
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      waited = 0; got_grant = 1'b0;
      while (!got_grant && waited < 20) begin
        step();
        waited++;
        got_grant = wr_en || rd_en;
      end
      check("rr_grant_seen", 32'(got_grant), 32'h1);
      check("rr_order", 32'(wr_en), 32'((RR_EN && (g % 2 == 1)) ? 0 : 1));
      if (wr_en) wr_end = 1'b1; else rd_end = 1'b1;
      step();
      wr_end = 1'b0; rd_end = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      randomize_fields();
      rst_n    = ($urandom_range(0, 99) >= 2);
      init_end = ($urandom_range(0, 9) < 7);
      aref_req = ($urandom_range(0, 9) < 2);
      wr_req   = $urandom_range(0, 1) == 1;
      rd_req   = $urandom_range(0, 1) == 1;
      wr_oe    = $urandom_range(0, 1) == 1;
      aref_end = ($urandom_range(0, 9) < 3);
      wr_end   = ($urandom_range(0, 9) < 3);
      rd_end   = ($urandom_range(0, 9) < 3);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, SDRAM DQ width.
REQ-002 SHALL have parameter ADDR_W, default 12, SDRAM row/column address width.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports init_end/init_cmd/init_ba/init_addr  input  1/4/2/ADDR_W  init done level, init command {cs_n,ras_n,cas_n,we_n}, bank, address.
REQ-006 SHALL have ports aref_req/aref_end/aref_cmd/aref_addr  input  1/1/4/ADDR_W  auto-refresh request, done pulse, command, address.
REQ-007 SHALL have ports wr_req/wr_end/wr_cmd/wr_ba/wr_addr/wr_oe/wr_data  input  1/1/4/2/ADDR_W/1/DATA_W  write requester.
REQ-008 SHALL have ports rd_req/rd_end/rd_cmd/rd_ba/rd_addr  input  1/1/4/2/ADDR_W  read requester.
REQ-009 SHALL have ports aref_en/wr_en/rd_en  output  1 each  grant to the corresponding requester.
REQ-010 SHALL have ports sdram_cke/sdram_cs_n/sdram_ras_n/sdram_cas_n/sdram_we_n  output  1 each  SDRAM control pins.
REQ-011 SHALL have ports sdram_bank  output  2, sdram_addr  output  ADDR_W, sdram_dq  inout  DATA_W.

Function
REQ-012 SHALL implement states INIT, ARBIT, AREF, WRITE, READ.
REQ-013 SHALL stay in INIT until init_end=1, then enter ARBIT next cycle.
REQ-014 In ARBIT SHALL evaluate requests each cycle; priority aref_req > wr_req > rd_req; winner state entered next cycle.
REQ-015 SHALL hold the grant (aref_en/wr_en/rd_en) high for every cycle the FSM is in the matching state; at most one grant high at any time.
REQ-016 SHALL return to ARBIT the cycle after the active requester's *_end; *_end from a non-granted requester SHALL be ignored.
REQ-017 SHALL not preempt: aref_req arriving during WRITE/READ waits until ARBIT.
REQ-018 SHALL drive {sdram_cs_n,ras_n,cas_n,we_n}, sdram_bank, sdram_addr combinationally from the owning requester: INIT->init_*, AREF->aref_* (bank 2'b11), WRITE->wr_*, READ->rd_*, ARBIT->NOP 4'b0111, bank 2'b11, addr all-ones.
REQ-019 SHALL drive sdram_dq = wr_data only when state==WRITE and wr_oe=1; otherwise high-Z.
REQ-020 SHALL hold sdram_cke=1 at all times after reset.
REQ-021 A request asserted and dropped within ARBIT before sampling SHALL not be granted.

Reset
REQ-022 On rst_n=0 at a clk edge SHALL enter INIT, clear all grants, release sdram_dq; command outputs show init_cmd (INIT state) immediately.
REQ-023 Reset mid-WRITE/READ/AREF SHALL abort with no further grant until init_end is re-seen.

Configuration
REQ-024 Macro SDRAM_ARB_RR_EN defined: when wr_req and rd_req both pending in ARBIT (no aref_req), SHALL grant the one not served last (1-bit last-served flag, reset to "read", so write goes first).
REQ-025 Macro SDRAM_ARB_RR_EN undefined: write SHALL always beat read; no last-served flag exists.

Structure
REQ-026 Shared package sdram_pkg SHALL hold the state enum, command constants (NOP, PRECHARGE, AREF, ACTIVE, WRITE, READ, MRS) and default bank/address constants.
REQ-027 Output command mux SHALL be one sub-module sdram_cmd_mux (select = state, pure combinational); FSM and RR flag stay in sdram_arbiter.

Verification
REQ-028 init_end rises at cycle 10 -> state ARBIT at cycle 11; outputs NOP 4'b0111, no grant.
REQ-029 aref_req and wr_req both high in ARBIT -> aref_en next cycle; after aref_end, ARBIT, then wr_en.
REQ-030 wr_req=1 with wr_oe=1, wr_data=16'h1234 -> sdram_dq=16'h1234 only during WRITE; high-Z in READ/ARBIT.
REQ-031 wr_req and rd_req held high continuously -> with SDRAM_ARB_RR_EN grants alternate W,R,W,R; without, W every time.
REQ-032 rst_n=0 during WRITE -> next cycle state INIT, wr_en=0, sdram_dq high-Z; rd_end pulse during WRITE ignored.
